// File: rtl/irq_pkg.sv
`default_nettype none
// ============================================================================
// Module   : irq_pkg
// Brief    : Shared constants and state encoding for the trap responder.
// Revision : 1.0
// ============================================================================
package irq_pkg;

  localparam logic [2:0] CSR_MSTATUS = 3'd0;
  localparam logic [2:0] CSR_MTVEC   = 3'd1;
  localparam logic [2:0] CSR_MEPC    = 3'd2;
  localparam logic [2:0] CSR_MCAUSE  = 3'd3;

  localparam int MIE_BIT  = 3;
  localparam int MPIE_BIT = 7;

  localparam logic [31:0] CAUSE_TIMER = 32'h8000_0007;
  localparam logic [31:0] CAUSE_EXT   = 32'h8000_000B;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    ACK  = 1'b1
  } state_e;

endpackage
`default_nettype wire

// File: rtl/irq_responder_if.sv
`default_nettype none
// ============================================================================
// Module   : irq_responder_if
// Brief    : Controller handshake, retire/fetch and CSR bus of the responder.
// Revision : 1.0
// ============================================================================
interface irq_responder_if;

  logic        interrupt;
  logic        int_istimer;
  logic        int_reply;
  logic        commit;
  logic [31:0] commit_pc_next;
  logic        mret;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [2:0]  csr_a;
  logic [31:0] csr_d;
  logic        csr_we;
  logic [31:0] csr_spo;
  logic        irq_active;

  modport master (
    output interrupt, int_istimer, commit, commit_pc_next, mret,
           csr_a, csr_d, csr_we,
    input  int_reply, redirect, redirect_pc, csr_spo, irq_active
  );

  modport slave (
    input  interrupt, int_istimer, commit, commit_pc_next, mret,
           csr_a, csr_d, csr_we,
    output int_reply, redirect, redirect_pc, csr_spo, irq_active
  );

endinterface
`default_nettype wire

// File: rtl/irq_csr_regs.sv
`default_nettype none
// ============================================================================
// Module   : irq_csr_regs
// Brief    : mstatus/mtvec/mepc/mcause storage with read mux and write masking.
// Revision : 1.0
// ============================================================================
module irq_csr_regs
  import irq_pkg::*;
#(
  parameter logic [31:0] RESET_VEC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  csr_a_i,
  input  logic [31:0] csr_d_i,
  input  logic        csr_we_i,
  input  logic        take_i,
  input  logic        take_timer_i,
  input  logic [31:0] take_pc_i,
  input  logic        mret_i,
  output logic [31:0] csr_spo_o,
  output logic        mie_o,
  output logic [31:0] mtvec_o,
  output logic [31:0] mepc_o
);

  logic        mie_q, mie_d;
  logic        mpie_q, mpie_d;
  logic [31:0] mtvec_q, mtvec_d;
  logic [31:0] mepc_q, mepc_d;
  logic [31:0] mcause_q, mcause_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      mie_q    <= 1'b0;
      mpie_q   <= 1'b0;
      mtvec_q  <= RESET_VEC;
      mepc_q   <= '0;
      mcause_q <= '0;
    end else begin
      mie_q    <= mie_d;
      mpie_q   <= mpie_d;
      mtvec_q  <= mtvec_d;
      mepc_q   <= mepc_d;
      mcause_q <= mcause_d;
    end
  end

  // Software write first; hardware trap/return updates override it below.
  always_comb begin
    mie_d    = mie_q;
    mpie_d   = mpie_q;
    mtvec_d  = mtvec_q;
    mepc_d   = mepc_q;
    mcause_d = mcause_q;
    if (csr_we_i) begin
      case (csr_a_i)
        CSR_MSTATUS: begin
          mie_d  = csr_d_i[MIE_BIT];
          mpie_d = csr_d_i[MPIE_BIT];
        end
        CSR_MTVEC:  mtvec_d  = csr_d_i & ~32'h3;
        CSR_MEPC:   mepc_d   = csr_d_i & ~32'h3;
        CSR_MCAUSE: mcause_d = csr_d_i;
        default: ;
      endcase
    end
    if (take_i) begin
      mepc_d   = take_pc_i & ~32'h3;
      mcause_d = take_timer_i ? CAUSE_TIMER : CAUSE_EXT;
      mpie_d   = mie_q;
      mie_d    = 1'b0;
    end
    if (mret_i) begin
      mie_d  = mpie_q;
      mpie_d = 1'b1;
    end
  end

  always_comb begin
    csr_spo_o = '0;
    case (csr_a_i)
      CSR_MSTATUS: begin
        csr_spo_o[MIE_BIT]  = mie_q;
        csr_spo_o[MPIE_BIT] = mpie_q;
      end
      CSR_MTVEC:  csr_spo_o = mtvec_q;
      CSR_MEPC:   csr_spo_o = mepc_q;
      CSR_MCAUSE: csr_spo_o = mcause_q;
      default: ;
    endcase
  end

  assign mie_o   = mie_q;
  assign mtvec_o = mtvec_q;
  assign mepc_o  = mepc_q;

endmodule
`default_nettype wire

// File: rtl/irq_responder.sv
`default_nettype none
// ============================================================================
// Module   : irq_responder
// Brief    : Takes interrupts at retire boundaries, redirects fetch, runs the
//            interrupt/int_reply handshake and returns on mret.
// Revision : 1.0
// ============================================================================
module irq_responder
  import irq_pkg::*;
#(
  parameter logic [31:0] RESET_VEC = 32'h0000_0000
) (
  input  logic           clk,
  input  logic           rst,
  irq_responder_if.slave bus
);

  state_e      state_q, state_d;
  logic        int_reply_q, int_reply_d;
  logic        redirect_q, redirect_d;
  logic [31:0] redirect_pc_q, redirect_pc_d;
  logic        irq_active_q, irq_active_d;

  logic        take;
  logic        mie;
  logic [31:0] mtvec;
  logic [31:0] mepc;

  irq_csr_regs #(
    .RESET_VEC (RESET_VEC)
  ) u_csr (
    .clk          (clk),
    .rst          (rst),
    .csr_a_i      (bus.csr_a),
    .csr_d_i      (bus.csr_d),
    .csr_we_i     (bus.csr_we),
    .take_i       (take),
    .take_timer_i (bus.int_istimer),
    .take_pc_i    (bus.commit_pc_next),
    .mret_i       (bus.mret),
    .csr_spo_o    (bus.csr_spo),
    .mie_o        (mie),
    .mtvec_o      (mtvec),
    .mepc_o       (mepc)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      int_reply_q   <= 1'b0;
      redirect_q    <= 1'b0;
      redirect_pc_q <= '0;
      irq_active_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      int_reply_q   <= int_reply_d;
      redirect_q    <= redirect_d;
      redirect_pc_q <= redirect_pc_d;
      irq_active_q  <= irq_active_d;
    end
  end

  // mret is excluded from the take so a simultaneous return wins.
  always_comb begin
    state_d       = state_q;
    int_reply_d   = int_reply_q;
    redirect_d    = 1'b0;
    redirect_pc_d = redirect_pc_q;
    irq_active_d  = irq_active_q;
    take          = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.interrupt && mie && bus.commit && !bus.mret) begin
          take          = 1'b1;
          state_d       = ACK;
          int_reply_d   = 1'b1;
          redirect_d    = 1'b1;
          redirect_pc_d = mtvec;
          irq_active_d  = 1'b1;
        end
      end
      ACK: begin
        if (!bus.interrupt) begin
          int_reply_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (bus.mret) begin
      redirect_d    = 1'b1;
      redirect_pc_d = mepc;
      irq_active_d  = 1'b0;
    end
  end

  assign bus.int_reply   = int_reply_q;
  assign bus.redirect    = redirect_q;
  assign bus.redirect_pc = redirect_pc_q;
  assign bus.irq_active  = irq_active_q;

endmodule
`default_nettype wire

// File: tb/tb_irq_responder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_irq_responder
// Brief    : Scoreboard bench with a rule-level trap model and controller model.
// Revision : 1.0
// ============================================================================
module tb_irq_responder;
  import irq_pkg::*;

  localparam logic [31:0] RV = 32'h0000_0040;

  logic clk = 1'b0;
  logic rst = 1'b1;

  irq_responder_if bus();

  irq_responder #(.RESET_VEC(RV)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #10 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] pc;
    int          due;
  } exp_t;
  exp_t sbq[$];

  // Architectural view of the trap state; m_age counts cycles of int_reply high.
  bit          m_mie, m_mpie, m_active;
  logic [31:0] m_mtvec, m_mepc, m_mcause;
  int          m_age;
  bit          ctl_line, ctl_tmr;
  int          rcnt;
  bit          mon_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, want %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (mon_en) begin
      if (sbq.size() != 0 && sbq[0].due == cyc) begin
        e = sbq.pop_front();
        chk("redirect", 32'(bus.redirect), 32'd1);
        chk("redirect_pc", bus.redirect_pc, e.pc);
      end else begin
        chk("no_redirect", 32'(bus.redirect), 32'd0);
      end
    end
  end

  task automatic model_reset();
    m_mie = 0; m_mpie = 0; m_active = 0;
    m_mtvec = RV; m_mepc = '0; m_mcause = '0;
    m_age = 0; ctl_line = 0; rcnt = 0;
  endtask

  task automatic rd(input logic [2:0] a, input logic [31:0] exp, input string name);
    bus.csr_we = 1'b0;
    bus.csr_a  = a;
    #1;
    chk(name, bus.csr_spo, exp);
  endtask

  task automatic check_state();
    logic [31:0] ms;
    ms = '0;
    ms[3] = m_mie;
    ms[7] = m_mpie;
    chk("int_reply", 32'(bus.int_reply), 32'(m_age != 0));
    chk("irq_active", 32'(bus.irq_active), 32'(m_active));
    rd(CSR_MSTATUS, ms, "mstatus");
    rd(CSR_MTVEC, m_mtvec, "mtvec");
    rd(CSR_MEPC, m_mepc, "mepc");
    rd(CSR_MCAUSE, m_mcause, "mcause");
    rd(3'(4 + $urandom_range(3)), 32'h0, "unused_csr");
  endtask

  task automatic step(input bit c, input logic [31:0] pc, input bit m, input bit we,
                      input logic [2:0] a, input logic [31:0] d, input bit r);
    bit take, o_mie, o_mpie;
    check_state();
    // Controller registers the reply and drops its request on the third cycle.
    if (bus.int_reply) rcnt++; else rcnt = 0;
    if (rcnt == 3) ctl_line = 0;
    bus.interrupt      = ctl_line;
    bus.int_istimer    = ctl_tmr;
    bus.commit         = c;
    bus.commit_pc_next = pc;
    bus.mret           = m;
    bus.csr_we         = we;
    bus.csr_a          = a;
    bus.csr_d          = d;
    rst                = r;
    if (r) begin
      model_reset();
    end else begin
      o_mie  = m_mie;
      o_mpie = m_mpie;
      take   = ctl_line && m_mie && c && !m && (m_age == 0);
      if (m || take) sbq.push_back('{pc: (m ? m_mepc : m_mtvec), due: cyc + 1});
      if (we) begin
        case (a)
          3'd0: begin m_mie = d[3]; m_mpie = d[7]; end
          3'd1: m_mtvec  = d & ~32'h3;
          3'd2: m_mepc   = d & ~32'h3;
          3'd3: m_mcause = d;
          default: ;
        endcase
      end
      if (m) begin
        m_mie = o_mpie; m_mpie = 1; m_active = 0;
      end else if (take) begin
        m_mepc   = pc & ~32'h3;
        m_mcause = ctl_tmr ? 32'h8000_0007 : 32'h8000_000B;
        m_mpie   = o_mie; m_mie = 0; m_active = 1;
      end
      if (take) m_age = 1;
      else if (m_age != 0) m_age = (m_age == 3) ? 0 : m_age + 1;
    end
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, '0, 0, 0, 3'd0, '0, 0);
  endtask

  initial begin
    int hi;
    bus.interrupt = 0; bus.int_istimer = 0; bus.commit = 0; bus.commit_pc_next = '0;
    bus.mret = 0; bus.csr_a = '0; bus.csr_d = '0; bus.csr_we = 0;
    ctl_tmr = 0;
    model_reset();
    repeat (2) @(negedge clk);
    mon_en = 1'b1;

    // Basic timer take
    step(0, '0, 0, 1, CSR_MTVEC, 32'h100, 0);
    step(0, '0, 0, 1, CSR_MSTATUS, 32'h8, 0);
    ctl_line = 1; ctl_tmr = 1;
    step(1, 32'h2004, 0, 0, 3'd0, '0, 0);
    chk("t1_redirect_pc", bus.redirect_pc, 32'h100);
    chk("t1_reply", 32'(bus.int_reply), 32'd1);
    rd(CSR_MEPC, 32'h2004, "t1_mepc");
    rd(CSR_MCAUSE, 32'h8000_0007, "t1_mcause");
    rd(CSR_MSTATUS, 32'h80, "t1_mstatus");

    // Handshake length
    hi = 1;
    for (int i = 0; i < 5; i++) begin
      idle(1);
      if (bus.int_reply) hi++;
    end
    chk("t2_reply_len", 32'(hi), 32'd3);

    // Masked request held over many commits
    step(0, '0, 0, 1, CSR_MSTATUS, 32'h0, 0);
    ctl_line = 1; ctl_tmr = 0;
    for (int i = 0; i < 10; i++) step(1, $urandom, 0, 0, 3'd0, '0, 0);
    chk("t3_masked_reply", 32'(bus.int_reply), 32'd0);
    step(0, '0, 0, 1, CSR_MSTATUS, 32'h8, 0);
    step(1, 32'h2004, 0, 0, 3'd0, '0, 0);
    rd(CSR_MCAUSE, 32'h8000_000B, "t3_mcause");
    idle(4);

    // mret, then mret colliding with a take
    step(0, '0, 1, 0, 3'd0, '0, 0);
    chk("t4_mret_pc", bus.redirect_pc, 32'h2004);
    chk("t4_active", 32'(bus.irq_active), 32'd0);
    rd(CSR_MSTATUS, 32'h88, "t4_mstatus");
    ctl_line = 1;
    step(1, 32'h3000, 1, 0, 3'd0, '0, 0);
    chk("t4_collide_reply", 32'(bus.int_reply), 32'd0);
    step(1, 32'h3008, 0, 0, 3'd0, '0, 0);
    rd(CSR_MEPC, 32'h3008, "t4_mepc");
    idle(4);

    // CSR writes racing a take
    step(0, '0, 1, 0, 3'd0, '0, 0);
    ctl_line = 1;
    step(1, 32'h4000, 0, 1, CSR_MTVEC, 32'h200, 0);
    chk("t5_old_mtvec", bus.redirect_pc, 32'h100);
    rd(CSR_MTVEC, 32'h200, "t5_mtvec");
    idle(4);
    step(0, '0, 1, 0, 3'd0, '0, 0);
    ctl_line = 1;
    step(1, 32'h5000, 0, 1, CSR_MEPC, 32'h5555, 0);
    rd(CSR_MEPC, 32'h5000, "t5_mepc");
    idle(1);

    // Reset in the middle of the handshake
    chk("t6_pre_reply", 32'(bus.int_reply), 32'd1);
    step(0, '0, 0, 0, 3'd0, '0, 1);
    chk("t6_reply", 32'(bus.int_reply), 32'd0);
    chk("t6_redirect", 32'(bus.redirect), 32'd0);
    rd(CSR_MTVEC, RV, "t6_mtvec");
    rd(CSR_MEPC, 32'h0, "t6_mepc");
    rd(CSR_MSTATUS, 32'h0, "t6_mstatus");

    // Randomised traffic
    for (int i = 0; i < 600; i++) begin
      if (!ctl_line && !bus.int_reply && $urandom_range(3) == 0) begin
        ctl_line = 1;
        ctl_tmr  = ($urandom_range(1) == 1);
      end
      step(($urandom_range(1) == 1), $urandom, ($urandom_range(15) == 0),
           ($urandom_range(3) == 0), 3'($urandom_range(7)), $urandom,
           ($urandom_range(199) == 0));
    end
    idle(3);
    chk("sb_drain", 32'(sbq.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/irq_responder.md
Name: irq_responder

Overview:
- CPU-side responder for the interrupt controller's `interrupt`/`int_reply` handshake in pCPU.
- Takes a pending interrupt at an instruction boundary, saves the return PC and cause, and redirects fetch to the trap vector.
- Acknowledges the controller and restores state on `mret`.
- Owns the small machine-mode trap CSR set: mstatus, mtvec, mepc, mcause.

Parameters:
- RESET_VEC, 32'h0000_0000, reset value of mtvec.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- interrupt  in  1  level request from interrupt controller; held until acknowledged
- int_istimer  in  1  request source is the timer; valid while interrupt=1
- int_reply  out  1  acknowledge to controller (registered)
- commit  in  1  an instruction retires this cycle; safe trap point
- commit_pc_next  in  32  PC of the next instruction to execute after the retiring one
- mret  in  1  mret retiring this cycle (single-cycle pulse)
- redirect  out  1  one-cycle fetch redirect strobe (registered)
- redirect_pc  out  32  redirect target; valid when redirect=1
- csr_a  in  3  CSR select: 0 mstatus, 1 mtvec, 2 mepc, 3 mcause
- csr_d  in  32  CSR write data
- csr_we  in  1  CSR write enable
- csr_spo  out  32  combinational CSR read data; 0 for unused addresses
- irq_active  out  1  high from trap entry until mret (debug/stall hint)

Behaviour:
- Reset values:
  - MIE=0, MPIE=0, mtvec=RESET_VEC, mepc=0, mcause=0.
  - int_reply=0, redirect=0, redirect_pc=0, irq_active=0, state=IDLE.
- mstatus layout: bit3 MIE, bit7 MPIE; all other bits read 0 and are ignored on write.
- Write masking: mtvec[1:0] and mepc[1:0] are forced to 0 on write.
- States: IDLE, ACK.
- IDLE, take condition: interrupt=1 & MIE=1 & commit=1 & mret=0. At the next edge:
  - mepc <= commit_pc_next & ~3.
  - mcause <= 32'h8000_0007 if int_istimer, else 32'h8000_000B.
  - MPIE <= MIE; MIE <= 0; irq_active <= 1.
  - redirect <= 1; redirect_pc <= current mtvec.
  - int_reply <= 1; state <= ACK.
  - Take latency: 1 cycle from the qualifying commit to the redirect strobe.
- IDLE, no take: with interrupt=1 but MIE=0 or commit=0, nothing happens. The request stays pending at the controller.
- ACK:
  - int_reply is held at 1 until interrupt is sampled 0, then int_reply <= 0 and state <= IDLE.
  - The controller registers the reply, so interrupt normally falls 2 cycles after int_reply rises, and int_reply is high for 3 cycles.
  - No new take occurs in ACK.
- mret (any state), at the next edge:
  - MIE <= MPIE; MPIE <= 1; irq_active <= 0.
  - redirect <= 1; redirect_pc <= mepc.
  - State is unaffected, so an mret during ACK does not cut short the handshake.
- redirect is 0 in every cycle that is not a take or mret edge.
- Simultaneous events:
  - mret and take condition: mret wins; the take is deferred to a later commit (MIE restored).
  - CSR write and take/mret to mstatus/mepc/mcause: hardware update wins; the software write is dropped.
  - mtvec write in a take cycle: the write lands, but redirect_pc uses the pre-write mtvec.
  - CSR write with no hardware event: takes effect at the next edge; csr_spo reflects it the cycle after.
- Level re-assertion: a request re-raised while MIE=0 (inside the handler) is taken only after mret restores MIE.
- Reset mid-ACK: all state returns to reset values and int_reply drops next edge. The controller shares rst, so no stale handshake remains.

Decomposition:
- Shared package irq_pkg:
  - CSR addresses (CSR_MSTATUS=0, CSR_MTVEC=1, CSR_MEPC=2, CSR_MCAUSE=3).
  - MIE_BIT=3, MPIE_BIT=7.
  - CAUSE_TIMER=32'h8000_0007, CAUSE_EXT=32'h8000_000B.
  - State encodings IDLE/ACK.
- One sub-module is natural: irq_csr_regs.
  - Holds the four registers, read mux and write masking.
  - Takes hardware-update strobes with priority over the software write.
- The handshake FSM stays in irq_responder.

Test Plan:
1. Write mtvec=0x100 and mstatus=0x8; raise interrupt with int_istimer=1; commit=1 with commit_pc_next=0x2004 -> next cycle redirect=1, redirect_pc=0x100, mepc=0x2004, mcause=0x80000007, mstatus reads 0x80, int_reply=1.
2. Controller model that drops interrupt 2 cycles after int_reply -> int_reply high exactly 3 cycles, state back to IDLE, no second redirect.
3. MIE=0 with interrupt held high over 10 commits -> no redirect and int_reply stays 0. Then write mstatus=0x8 -> take on the next commit.
4. Pulse mret with mepc=0x2004 and MPIE=1 -> redirect_pc=0x2004, MIE=1, irq_active=0. Then mret and take condition in the same cycle -> only the mret redirect, and the take happens on the following commit.
5. Take cycle with a concurrent csr_we to mtvec=0x200 -> redirect_pc=old mtvec 0x100; mtvec reads 0x200 afterwards. Concurrent mepc write in a take cycle -> discarded.
6. Assert rst during ACK with int_reply=1 -> int_reply=0, redirect=0, mtvec=RESET_VEC, all other CSRs 0 after one edge.
